// File: rtl/rfft_4pt_ctrl.sv
// ============================================================================
// rfft_4pt_ctrl : job sequencer (load, two butterfly passes, unload) for the
//                 4-point real-FFT datapath.  Rev 1.0
// ============================================================================
`default_nettype none

module rfft_4pt_ctrl #(
  parameter int ADDR_BIT = 3,
  parameter int RD_LAT   = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  busy,
  output logic                  done,
  output logic                  out_valid,
  output logic [ADDR_BIT-1:0]   out_addr,
  output logic                  m0,
  output logic                  m11,
  output logic [1:0]            m12,
  output logic [1:0]            m13,
  output logic                  m14,
  output logic                  m21,
  output logic                  m22,
  output logic                  m23,
  output logic                  m24,
  output logic                  bypass_en,
  output logic                  w_sel,
  output logic [4*ADDR_BIT-1:0] addr_read,
  output logic [4*ADDR_BIT-1:0] addr_write
);

  localparam int FRAMES = (1 << ADDR_BIT) - 1;
  localparam int CNT_W  = $clog2(FRAMES + RD_LAT + 1);

  localparam logic [ADDR_BIT-1:0] c_SCRATCH = ADDR_BIT'((1 << ADDR_BIT) - 1);
  localparam logic [CNT_W-1:0]    c_FRAMES  = CNT_W'(FRAMES);
  localparam logic [CNT_W-1:0]    c_RD_LAT  = CNT_W'(RD_LAT);
  localparam logic [CNT_W-1:0]    c_LAST    = CNT_W'(FRAMES + RD_LAT - 1);
  localparam logic [CNT_W-1:0]    c_LOADEND = CNT_W'(FRAMES - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
    S_COMP   = 2'd2,
    S_UNLOAD = 2'd3
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_cnt,   w_cnt_nxt;
  logic               r_pass,  w_pass_nxt;
  logic               r_done,  w_done_nxt;
  logic [ADDR_BIT-1:0] w_rd_addr, w_wr_addr;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_pass  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_pass  <= w_pass_nxt;
      r_done  <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_pass_nxt  = r_pass;
    w_done_nxt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_LOAD;
          w_cnt_nxt   = '0;
        end
      end
      S_LOAD: begin
        if (in_valid) begin
          if (r_cnt == c_LOADEND) begin
            w_state_nxt = S_COMP;
            w_cnt_nxt   = '0;
            w_pass_nxt  = 1'b0;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
      end
      S_COMP: begin
        if (r_cnt == c_LAST) begin
          w_cnt_nxt = '0;
          if (r_pass) begin
            w_state_nxt = S_UNLOAD;
          end else begin
            w_pass_nxt = 1'b1;
          end
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_UNLOAD: begin
        if (r_cnt == c_LAST) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
          w_done_nxt  = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // RAM write is always enabled, so every non-result write is steered to SCRATCH
  always_comb begin
    in_ready  = 1'b0;
    busy      = (r_state != S_IDLE);
    done      = r_done;
    out_valid = 1'b0;
    out_addr  = '0;
    m0        = 1'b0;
    m11       = 1'b0;
    m12       = 2'd0;
    m13       = 2'd0;
    m14       = 1'b0;
    m21       = 1'b0;
    m22       = 1'b0;
    m23       = 1'b0;
    m24       = 1'b0;
    bypass_en = 1'b1;
    w_sel     = 1'b0;
    w_rd_addr = '0;
    w_wr_addr = c_SCRATCH;
    case (r_state)
      S_LOAD: begin
        in_ready  = 1'b1;
        w_wr_addr = ADDR_BIT'(r_cnt);
      end
      S_COMP: begin
        m0        = 1'b1;
        bypass_en = 1'b0;
        w_sel     = r_pass;
        m12       = r_pass ? 2'd1 : 2'd2;
        m13       = r_pass ? 2'd1 : 2'd0;
        m14       = 1'b1;
        m23       = 1'b1;
        m24       = 1'b1;
        w_rd_addr = (r_cnt < c_FRAMES) ? ADDR_BIT'(r_cnt) : c_SCRATCH;
        w_wr_addr = (r_cnt >= c_RD_LAT) ? ADDR_BIT'(r_cnt - c_RD_LAT) : c_SCRATCH;
      end
      S_UNLOAD: begin
        m0        = 1'b1;
        w_rd_addr = (r_cnt < c_FRAMES) ? ADDR_BIT'(r_cnt) : c_SCRATCH;
        if (r_cnt >= c_RD_LAT) begin
          out_valid = 1'b1;
          out_addr  = ADDR_BIT'(r_cnt - c_RD_LAT);
        end
      end
      default: begin
      end
    endcase
  end

  assign addr_read  = {4{w_rd_addr}};
  assign addr_write = {4{w_wr_addr}};

endmodule

`default_nettype wire

// File: tb/tb_rfft_4pt_ctrl.sv
// ============================================================================
// tb_rfft_4pt_ctrl : randomized self-checking bench against a phase/RAM model.
//                    Rev 1.0
// ============================================================================
`default_nettype none

module tb_rfft_4pt_ctrl;

  localparam int NF = 7;

  logic        clk = 1'b0;
  logic        rst, start, in_valid;
  logic        in_ready, busy, done, out_valid;
  logic [2:0]  out_addr;
  logic        m0, m11, m14, m21, m22, m23, m24, bypass_en, w_sel;
  logic [1:0]  m12, m13;
  logic [11:0] addr_read, addr_write;

  logic [31:0] ram [8];
  int          n_total = 0;
  int          n_bad   = 0;

  always #5 clk = ~clk;

  rfft_4pt_ctrl #(.ADDR_BIT(3), .RD_LAT(1)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
    .in_ready(in_ready), .busy(busy), .done(done), .out_valid(out_valid),
    .out_addr(out_addr), .m0(m0), .m11(m11), .m12(m12), .m13(m13), .m14(m14),
    .m21(m21), .m22(m22), .m23(m23), .m24(m24), .bypass_en(bypass_en),
    .w_sel(w_sel), .addr_read(addr_read), .addr_write(addr_write)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ph: 0 idle (a=done), 1 load (a=beats taken), 2 comp (a=pass, j=step), 3 unload (j=step)
  task automatic check_phase(input int ph, input int a, input int j);
    logic [6:0]  e_ctl;
    logic [12:0] e_mux;
    logic [2:0]  e_rd, e_wr;
    logic        ov;
    e_ctl = '0;
    e_mux = {1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 4'b0000, 1'b1, 1'b0};
    e_rd  = 3'd0;
    e_wr  = 3'd7;
    ov    = 1'b0;
    case (ph)
      0: e_ctl = {2'b00, a[0], 1'b0, 3'd0};
      1: begin
        e_ctl = {2'b11, 2'b00, 3'd0};
        e_wr  = 3'(a);
      end
      2: begin
        e_ctl = {2'b01, 2'b00, 3'd0};
        e_mux = {1'b1, 1'b0, (a != 0) ? 2'd1 : 2'd2, (a != 0) ? 2'd1 : 2'd0, 1'b1,
                 4'b0011, 1'b0, a[0]};
        e_rd  = (j < NF) ? 3'(j) : 3'd7;
        e_wr  = (j >= 1) ? 3'(j - 1) : 3'd7;
      end
      default: begin
        ov    = (j >= 1);
        e_ctl = {2'b01, 1'b0, ov, ov ? 3'(j - 1) : 3'd0};
        e_mux = {1'b1, 1'b0, 2'd0, 2'd0, 1'b0, 4'b0000, 1'b1, 1'b0};
        e_rd  = (j < NF) ? 3'(j) : 3'd7;
      end
    endcase
    chk($sformatf("ctl ph%0d a%0d j%0d", ph, a, j),
        {25'd0, in_ready, busy, done, out_valid, out_addr}, {25'd0, e_ctl});
    chk($sformatf("mux ph%0d a%0d j%0d", ph, a, j),
        {19'd0, m0, m11, m12, m13, m14, m21, m22, m23, m24, bypass_en, w_sel}, {19'd0, e_mux});
    if (ph != 1)
      chk($sformatf("rd ph%0d j%0d", ph, j), {20'd0, addr_read}, {20'd0, {4{e_rd}}});
    chk($sformatf("wr ph%0d a%0d j%0d", ph, a, j), {20'd0, addr_write}, {20'd0, {4{e_wr}}});
  endtask

  // Model the always-on RAM write for the cycle about to end
  task automatic ram_edge(input logic [31:0] hd);
    logic [2:0]  wa;
    logic [31:0] wd;
    wa = addr_write[2:0];
    wd = m0 ? (32'hC000_0000 | 32'(wa)) : hd;
    @(posedge clk);
    ram[wa] = wd;
    #1;
  endtask

  task automatic start_job();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // mode: 0 always valid, 1 valid pattern 1,0,0, 2 random; abort_k >= 0 resets at that COMP/UNLOAD step
  task automatic run_body(input int mode, input int abort_k);
    int          n;
    int          i;
    logic        v;
    logic [31:0] hd;
    logic [31:0] acc [NF];
    n = 0;
    i = 0;
    for (int a = 0; a < 8; a++) ram[a] = 32'hDEAD_0000 | 32'(a);
    hd = $urandom & 32'h3FFF_FFFF;
    while (n < NF && i < 100) begin
      check_phase(1, n, 0);
      if (mode == 0)      v = 1'b1;
      else if (mode == 1) v = (i % 3 == 0);
      else                v = 1'($urandom_range(0, 1));
      in_valid = v;
      start    = (i == 4) || ($urandom_range(0, 7) == 0);
      ram_edge(hd);
      if (v) begin
        acc[n] = hd;
        n++;
        hd = $urandom & 32'h3FFF_FFFF;
      end
      i++;
    end
    in_valid = 1'b0;
    start    = 1'b0;
    if (n < NF) begin
      chk("load_budget", 32'(n), 32'(NF));
      return;
    end
    for (int k = 0; k < 24; k++) begin
      if (k == 0)
        for (int f = 0; f < NF; f++) chk($sformatf("ram_frame%0d", f), ram[f], acc[f]);
      if (k < 16) check_phase(2, k / 8, k % 8);
      else        check_phase(3, 0, k % 8);
      if (k == abort_k) begin
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_phase(0, 0, 0);
        return;
      end
      start = (k == 12) || (k < 23 && $urandom_range(0, 7) == 0);
      ram_edge(32'h1234_5678);
    end
    start = 1'b0;
    check_phase(0, 1, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_phase(0, 0, 0);
    rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      check_phase(0, 0, 0);
    end

    // unstalled job, then a start on the done cycle chaining a stalled job
    start_job();
    run_body(0, -1);
    start_job();
    run_body(1, -1);
    @(posedge clk);
    #1;
    check_phase(0, 0, 0);

    // reset during pass 0 (cycle 12), then a clean job
    start_job();
    run_body(0, 4);
    @(posedge clk);
    #1;
    check_phase(0, 0, 0);
    start_job();
    run_body(0, -1);

    // randomized stall jobs with random idle gaps
    for (int r = 0; r < 4; r++) begin
      repeat ($urandom_range(1, 3)) begin
        @(posedge clk);
        #1;
        check_phase(0, 0, 0);
      end
      start_job();
      run_body(2, -1);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/rfft_4pt_ctrl.md
Name: rfft_4pt_ctrl

Overview:
- Sequencer that drives every control input of the 4-point real-FFT datapath: m0, m11–m14, m21–m24, bypass_en, addr_read and addr_write.
- Runs one job as four phases: load frames from the host, two butterfly passes in place, then unload results.
- Sits between the host/stream interface and the datapath. The datapath's data buses (in0–in3, mem0–mem3) connect outside this block; this block only tells the host when to present or capture them.
- The datapath RAM write enable is permanently on, so every cycle writes somewhere. Any write that does not carry a valid result is parked on a scratch address.

Parameters:
- ADDR_BIT, 3: bank address width.
  - FRAMES = 2^ADDR_BIT − 1 usable frame addresses (0..FRAMES−1).
  - SCRATCH = 2^ADDR_BIT − 1 is the parking address.
- RD_LAT, 1: cycles from addr_read presentation to the corresponding result at the datapath out0–out3 / mem outputs.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  job request; honoured only in IDLE
- in_valid  in  1  host presents frame on in0–in3
- in_ready  out  1  controller accepts a frame this cycle
- busy  out  1  job in progress (state != IDLE)
- done  out  1  one-cycle pulse at job end
- out_valid  out  1  mem0–mem3 carry result frame out_addr
- out_addr  out  ADDR_BIT  frame index of current result
- m0  out  1  0 = write host input, 1 = write PE output
- m11  out  1  PE input-0 select
- m12  out  2  PE input-1 select
- m13  out  2  PE input-2 select
- m14  out  1  PE input-3 select
- m21, m22, m23, m24  out  1 each  PE output routing selects
- bypass_en  out  1  PE bypass
- w_sel  out  1  twiddle select, equal to the pass index
- addr_read  out  4*ADDR_BIT  read addresses, bank0 in the LSBs
- addr_write  out  4*ADDR_BIT  write addresses, bank0 in the LSBs

Behaviour:
- All four bank address fields are always identical.

Reset:
- State becomes IDLE; all counters 0.
- Outputs: in_ready, busy, done, out_valid 0; out_addr 0; all mux selects 0; bypass_en 1; w_sel 0; addr_read all 0; addr_write all SCRATCH.
- rst mid-job aborts immediately. RAM contents are don't-care after an abort.

IDLE:
- Outputs hold at their reset values.
- start=1 moves to LOAD (cnt=0) on the next edge.

LOAD:
- in_ready=1, m0=0, addr_write=cnt, bypass_en=1.
- When in_valid=1: cnt increments.
- Host must keep in0–in3 stable until accepted. Writes during in_valid=0 cycles land at cnt and are overwritten by the accepted beat.
- On accepting beat FRAMES−1: go to COMP (pass=0, cnt=0).

COMP:
- in_ready=0, m0=1, bypass_en=0, w_sel=pass.
- Each pass lasts FRAMES+RD_LAT cycles, with cnt running 0..FRAMES+RD_LAT−1.
- addr_read = cnt while cnt<FRAMES, else SCRATCH.
- addr_write = cnt−RD_LAT while cnt ≥ RD_LAT, else SCRATCH.
- Pass 0 selects: m11=0, m12=2, m13=0, m14=1 (pairs banks 0/2 and 1/3).
- Pass 1 selects: m11=0, m12=1, m13=1, m14=1 (pairs banks 0/1 and 2/3).
- Both passes: m21=0, m22=0, m23=1, m24=1.
- After pass 1 ends: go to UNLOAD (cnt=0).

UNLOAD:
- m0=1, addr_write=SCRATCH, bypass_en=1, all selects 0.
- addr_read = cnt for cnt<FRAMES, else SCRATCH.
- out_valid=1 with out_addr=cnt−RD_LAT for RD_LAT ≤ cnt < FRAMES+RD_LAT.
- No backpressure.
- After the last out_valid cycle: go to IDLE, with done=1 for exactly one cycle (the first IDLE cycle).

Other rules:
- start outside IDLE is ignored. start during the done cycle is honoured (that cycle is IDLE).
- All counters wrap only by explicit reload, never by overflow.

Timing (defaults, start sampled at edge 0, no stalls):
- LOAD cycles 1–7.
- COMP pass 0 cycles 8–15, pass 1 cycles 16–23.
- UNLOAD cycles 24–31; out_valid cycles 25–31 with out_addr 0..6.
- done and busy=0 at cycle 32.

Test Plan:
- Reset then idle: assert rst 3 cycles, hold start=0 for 10 cycles -> addr_write=SCRATCH(7) on all banks, bypass_en=1, busy=0, in_ready=0 throughout.
- Unstalled job: start pulse, in_valid held 1 -> in_ready cycles 1–7; m12=2 cycles 8–15; m12=1 and w_sel=1 cycles 16–23; out_valid cycles 25–31 with out_addr 0..6; done cycle 32 only.
- Load stalls: in_valid toggled 1,0,0,1,… -> cnt advances only on accepted beats; COMP starts the cycle after the 7th accept; frame k written with the k-th accepted data (checked via RAM model).
- Scratch parking: in each pass, cycle 0 addr_write=7 and cycle 7 addr_read=7; no write ever hits addresses 0–6 outside LOAD and the valid COMP windows.
- Reset mid-job: rst at cycle 12 (pass 0) -> next cycle IDLE values and no done; a fresh start then completes normally with done 32 cycles after start.
- Start ignored while busy: start re-pulsed at cycles 5 and 20 -> timeline unchanged; start on the done cycle -> in_ready high on the following cycle.
